s3_execute_stage: RTL
=====================

# s3_execute_stage

Stage 3 of the datapath: consumes the Stage 2 register outputs, selects the second operand (register or sign-extended immediate), performs the ALU operation and registers the result for write-back to the register file. It also forwards its own registered result back into the ALU inputs, so back-to-back dependent instructions execute without a stall. Its outputs drive the register file write port directly.

## Interface
No parameters; all widths fixed.
- Clk  input  1  clock for all sequential logic
- Reset  input  1  synchronous, active-high; clears all S3 state on the rising edge of Clk
- S2_ReadData1  input  32  first operand from Stage 2 register
- S2_ReadData2  input  32  second register operand from Stage 2 register
- S2_Imm  input  16  immediate from Stage 2 register
- S2_DataSrc  input  1  0: operand B = register, 1: operand B = sign-extended immediate
- S2_ALUOp  input  3  ALU operation
- S2_ReadSelect1  input  5  register index that produced S2_ReadData1 (forwarding compare)
- S2_ReadSelect2  input  5  register index that produced S2_ReadData2 (forwarding compare)
- S2_WriteSelect  input  5  destination register
- S2_WriteEnable  input  1  destination write enable
- S3_ALUOut  output  32  registered ALU result, register file write data
- S3_WriteSelect  output  5  registered destination, register file write address
- S3_WriteEnable  output  1  registered write enable
- S3_Zero  output  1  registered flag, 1 when the result is 0
- S3_Overflow  output  1  registered signed-overflow flag (ADD/SUB only, else 0)

## Operation
- Forwarding, combinational, evaluated every cycle:
  - Operand A = S3_ALUOut when S3_WriteEnable=1 and S3_WriteSelect==S2_ReadSelect1; else S2_ReadData1.
  - Register operand B = S3_ALUOut when S3_WriteEnable=1 and S3_WriteSelect==S2_ReadSelect2; else S2_ReadData2.
  - Register 0 is not special; index 0 forwards like any other.
- Operand B = DataSrc ? {{16{Imm[15]}}, Imm} : forwarded register B. Forwarding on B is ignored when DataSrc=1.
- ALUOp encoding, all 32-bit, results truncated to 32 bits:
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed A<B gives 1, else 0
  - 110 SLL: A << B[4:0]
  - 111 SRL: logical A >> B[4:0]
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - All other ops: 0.
- Zero = (result == 0), computed on the truncated result.
- The ALU result, flags, WriteSelect and WriteEnable all register on the rising edge of Clk.
- A bubble (S2_WriteEnable=0) still computes and registers a result. It clears S3_WriteEnable, which disables forwarding from that slot.

## Timing
- Latency is 1 cycle. Inputs valid before edge n appear on the S3 outputs after edge n.
- No handshake and no stall. The stage advances every cycle.
- Reset, on the edge with Reset=1:
  - S3_ALUOut=0, S3_WriteSelect=0, S3_WriteEnable=0, S3_Zero=0, S3_Overflow=0.
  - Reset has priority over all inputs.
- Reset mid-stream:
  - The in-flight result is discarded and not written.
  - Because S3_WriteEnable=0 after reset, the first post-reset instruction gets no forwarding.
- Simultaneous match on both operands (same source index twice): both operands take S3_ALUOut.
- Forwarding only covers distance 1. Distance-2 hazards are resolved by register-file write-before-read and are outside this block.

## Test plan
- Reset: hold Reset 2 cycles with nonzero inputs -> every output is 0, including S3_Zero=0.
- Basic ops: A=0x0000000C, B=0x00000005, DataSrc=0. Sweep ALUOp 000..111 -> results 0x11, 0x7, 0x4, 0xD, 0x9, 0x0 (Zero=1), 0x180, 0x0 one cycle later, with WriteSelect/WriteEnable echoed.
- Immediate sign-extension and overflow:
  - A=0x00000001, Imm=0xFFFF, DataSrc=1, ADD -> 0x00000000, Zero=1, Overflow=0.
  - A=0x7FFFFFFF, Imm=0x0001, ADD -> 0x80000000, Overflow=1.
- Forwarding:
  - Cycle n: write r3 = 5+6, giving S3_ALUOut=0x0B.
  - Cycle n+1: ReadSelect1=3 with stale ReadData1=0, B=1, ADD -> S3_ALUOut=0x0C.
  - Repeat with WriteEnable=0 in cycle n -> S3_ALUOut=0x01.
- Double forward and immediate override:
  - After r4=0x10, issue ReadSelect1=ReadSelect2=4, ADD -> 0x20.
  - Same but DataSrc=1, Imm=0x0002 -> 0x12.
- Reset mid-stream: after a write to r7 is registered, assert Reset one cycle. Next instruction reads r7 with ReadData1=0x3 -> no forwarding, result uses 0x3; all outputs are 0 during the reset cycle.

Source files
------------

// File: rtl/s3_execute_stage_if.sv
// Stage 2 -> Stage 3 operand bus and Stage 3 -> register-file write-back bus.
// The execute stage is the slave; whoever drives Stage 2 registers is the master.
interface s3_execute_stage_if;
  logic [31:0] S2_ReadData1;
  logic [31:0] S2_ReadData2;
  logic [15:0] S2_Imm;
  logic        S2_DataSrc;
  logic [2:0]  S2_ALUOp;
  logic [4:0]  S2_ReadSelect1;
  logic [4:0]  S2_ReadSelect2;
  logic [4:0]  S2_WriteSelect;
  logic        S2_WriteEnable;
  logic [31:0] S3_ALUOut;
  logic [4:0]  S3_WriteSelect;
  logic        S3_WriteEnable;
  logic        S3_Zero;
  logic        S3_Overflow;

  modport master (
    output S2_ReadData1, S2_ReadData2, S2_Imm, S2_DataSrc, S2_ALUOp,
           S2_ReadSelect1, S2_ReadSelect2, S2_WriteSelect, S2_WriteEnable,
    input  S3_ALUOut, S3_WriteSelect, S3_WriteEnable, S3_Zero, S3_Overflow
  );

  modport slave (
    input  S2_ReadData1, S2_ReadData2, S2_Imm, S2_DataSrc, S2_ALUOp,
           S2_ReadSelect1, S2_ReadSelect2, S2_WriteSelect, S2_WriteEnable,
    output S3_ALUOut, S3_WriteSelect, S3_WriteEnable, S3_Zero, S3_Overflow
  );
endinterface

// File: rtl/s3_execute_stage.sv
// Execute stage: operand forwarding from its own result register, operand-B select,
// 32-bit ALU with zero/overflow flags, one-cycle registered write-back outputs.
module s3_execute_stage (
  input  logic              Clk,
  input  logic              Reset,
  s3_execute_stage_if.slave bus
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  logic                     fwd_a_p0;
  logic                     fwd_b_p0;
  logic signed [DATA_W-1:0] imm_ext_p0;
  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] reg_b_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic signed [DATA_W-1:0] result_p0;
  logic                     ovf_p0;

  function automatic logic signed [DATA_W-1:0] alu (
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = (a < b) ? DATA_W'(1) : '0;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = $signed($unsigned(a) >> b[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Signed overflow is judged from operand and result sign bits only.
  function automatic logic overflow (
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] r
  );
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD:  v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Stage p0: forwarding, operand select and ALU (combinational)
  always_comb begin
    fwd_a_p0   = bus.S3_WriteEnable && (bus.S3_WriteSelect == bus.S2_ReadSelect1);
    fwd_b_p0   = bus.S3_WriteEnable && (bus.S3_WriteSelect == bus.S2_ReadSelect2);
    imm_ext_p0 = {{16{bus.S2_Imm[15]}}, bus.S2_Imm};
    op_a_p0    = fwd_a_p0 ? bus.S3_ALUOut : bus.S2_ReadData1;
    reg_b_p0   = fwd_b_p0 ? bus.S3_ALUOut : bus.S2_ReadData2;
    op_b_p0    = bus.S2_DataSrc ? imm_ext_p0 : reg_b_p0;
    result_p0  = alu(bus.S2_ALUOp, op_a_p0, op_b_p0);
    ovf_p0     = overflow(bus.S2_ALUOp, op_a_p0, op_b_p0, result_p0);
  end

  // Stage p1: write-back registers; reset also clears data so nothing stale forwards
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.S3_ALUOut      <= '0;
      bus.S3_WriteSelect <= '0;
      bus.S3_WriteEnable <= 1'b0;
      bus.S3_Zero        <= 1'b0;
      bus.S3_Overflow    <= 1'b0;
    end else begin
      bus.S3_ALUOut      <= result_p0;
      bus.S3_WriteSelect <= bus.S2_WriteSelect;
      bus.S3_WriteEnable <= bus.S2_WriteEnable;
      bus.S3_Zero        <= (result_p0 == '0);
      bus.S3_Overflow    <= ovf_p0;
    end
  end

endmodule
